tilt_stepper: RTL and testbench
===============================

# tilt_stepper

Conditions raw PmodACL accelerometer samples into paced per-axis step pulses for the ball-motion stage. Sits between the PmodACL SPI reader and `maze_and_ball`, driving its `xAxis`/`yAxis`/`zAxis` inputs. Those inputs move the ball one pixel on every `clk` where the magnitude bits are non-zero, so this block must assert magnitude bits only on single-cycle step pulses. The pulse rate is proportional to filtered tilt beyond a deadzone.

## Interface
- `AVG_LOG2`, 2, samples averaged per result = 2^AVG_LOG2 (legal range 0..4)
- `DEADZONE`, 8, averaged magnitude at or below which the axis is idle
- `TICK_DIV`, 100000, `clk` cycles per rate tick (1 kHz at 100 MHz); legal values are >= 2
- `clk`  in  1  system clock
- `rst`  in  1  synchronous, active-high reset
- `sample_valid`  in  1  one-cycle strobe; raw axes valid
- `x_raw`, `y_raw`, `z_raw`  in  10 each  two's-complement accelerometer samples
- `xAxis`, `yAxis`  out  10 each  bit 9 = direction (1 = negative); bits 8:0 = 9'd1 during a step pulse, else 0
- `zAxis`  out  10  latest averaged z, two's complement
- `tilt_valid`  out  1  one-cycle pulse when a new average is latched

## Operation
- **Reset:** all outputs are 0. Sum accumulators, sample counter, averages, rates, phases and tick counter are all 0.
- **Averaging:**
  - Each axis keeps a sign-extended sum of width 10+AVG_LOG2. Each accepted sample adds to it, and a counter counts accepted samples.
  - On the sample that makes the count 2^AVG_LOG2, the block latches `avg = (sum + sample) >>> AVG_LOG2` next cycle. The shift is arithmetic, so the result rounds toward −inf.
  - On that same cycle it clears the sum and counter and pulses `tilt_valid`.
  - `sample_valid` held high accepts one sample per cycle.
- **Rate:** registered one cycle after the average.
  - mag = |avg|. The value −512 saturates to 511.
  - rate = (mag > DEADZONE) ? mag − DEADZONE : 0, width 9 bits.
  - The sign register is set to 1 when avg < 0, else 0. It is updated together with rate.
- **Tick:** a counter runs 0..TICK_DIV−1. `tick` is high on the cycle the counter equals TICK_DIV−1, then the counter wraps to 0.
- **Phase accumulator (per axis, 9 bits):**
  - On `tick`: {carry, phase} = phase + rate. carry = 1 produces a step.
  - When rate = 0, phase is forced to 0, including immediately on entry to the deadzone.
  - At most one step per tick per axis.
- **Output:**
  - `xAxis = {sign_x, step_x ? 9'd1 : 9'd0}`, registered; `yAxis` is built the same way.
  - Bit 9 always reflects the current sign, including while idle.
  - `zAxis` = latched z average.
- **Simultaneous events:**
  - A sample completing an average in the same cycle as `tick`: both are processed, and the tick uses the old rate.
  - A new rate takes effect at the first tick after it is registered.
  - Phase is not cleared on rate change, except when rate goes to 0.
- **Reset mid-average:** the partial sum is discarded and the count restarts at 0.

## Timing
- Final sample on cycle N:
  - avg and `tilt_valid` on N+1
  - rate/sign on N+2
  - `xAxis` bit 9 updates on N+3
- Tick on cycle T with carry: `xAxis[8:0] = 1` on exactly cycle T+1, then returns to 0 on T+2.
- Steady rate r gives a step every 512/r ticks on average.
- Pipeline latency is fixed and has no stalls. There is no back-pressure; the downstream stage consumes every cycle.

## Test plan
- **Reset:** assert `rst` for 3 cycles while `sample_valid` toggles -> all outputs 0, no `tilt_valid`. After release, the first average requires 4 fresh samples.
- **Averaging / rounding (AVG_LOG2=2):**
  - x samples 3, 3, 3, −2 -> avg +1, `tilt_valid` one cycle after the 4th sample.
  - x samples −1, −1, −1, −2 -> avg −2.
- **Rate pacing (TICK_DIV=4, DEADZONE=8):** four samples of x = +264 -> rate 256, `xAxis` = 10'h001 for one cycle every 8 clks, bit 9 = 0.
- **Negative / saturation:** four samples of x = −512 (10'h200) -> rate 503, bit 9 = 1, pulses show 10'h201 for one cycle each.
- **Deadzone:** after motion, four samples of x = +8 -> no further pulses, `xAxis` = 10'h000, phase 0. Then x = +264 resumes with the first step 2 ticks later.
- **Simultaneous sample and tick:** arrange the 4th sample on a tick cycle -> that tick uses the old rate. The new rate applies from the next tick, and `tilt_valid` timing is unchanged.

Source files
------------

// File: rtl/tilt_stepper.sv
// Tilt stepper: turns raw accelerometer samples into paced one-cycle step pulses.
// Each axis is block-averaged over 2^AVG_LOG2 samples. X/Y tilt beyond DEADZONE
// drives a 9-bit phase accumulator. The accumulator advances on every rate tick,
// and each carry out of it emits a single-cycle step.
//
// Ports:
//   clk          system clock
//   rst          synchronous, active-high reset
//   sample_valid one-cycle strobe, raw axes valid
//   x_raw/y_raw/z_raw  10-bit two's-complement samples
//   xAxis/yAxis  {direction (1 = negative), 9'd1 on a step cycle else 0}
//   zAxis        latest averaged z, two's complement
//   tilt_valid   one-cycle pulse when a new average is latched
module tilt_stepper #(
    parameter int unsigned AVG_LOG2 = 2,
    parameter int unsigned DEADZONE = 8,
    parameter int unsigned TICK_DIV = 100000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       sample_valid,
    input  logic [9:0] x_raw,
    input  logic [9:0] y_raw,
    input  logic [9:0] z_raw,
    output logic [9:0] xAxis,
    output logic [9:0] yAxis,
    output logic [9:0] zAxis,
    output logic       tilt_valid
);

    localparam int unsigned SUM_W     = 10 + AVG_LOG2;
    localparam int unsigned CNT_W     = AVG_LOG2 + 1;
    localparam int unsigned CNT_LAST  = (1 << AVG_LOG2) - 1;
    localparam int unsigned TICK_W    = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam int unsigned TICK_LAST = TICK_DIV - 1;
    localparam logic [8:0]  DZ        = 9'(DEADZONE);

    logic [9:0]              raw_c      [3];
    logic signed [SUM_W-1:0] sum_q      [3];
    logic signed [SUM_W-1:0] sum_next_c [3];
    logic [9:0]              avg_q      [3];
    logic [CNT_W-1:0]        cnt_q;
    logic                    last_c;

    logic [8:0]              mag_c      [2];
    logic [8:0]              rate_c     [2];
    logic [8:0]              rate_q     [2];
    logic                    sign_q     [2];
    logic [8:0]              phase_q    [2];
    logic [9:0]              phase_sum_c[2];
    logic                    step_c     [2];

    logic [TICK_W-1:0]       tick_cnt_q;
    logic                    tick_c;

    assign raw_c[0] = x_raw;
    assign raw_c[1] = y_raw;
    assign raw_c[2] = z_raw;

    assign last_c = sample_valid && (cnt_q == CNT_W'(CNT_LAST));
    assign tick_c = (tick_cnt_q == TICK_W'(TICK_LAST));
    assign zAxis  = avg_q[2];

    // Running sum including the incoming sample (sign-extended).
    always_comb begin
        for (int i = 0; i < 3; i++) begin
            sum_next_c[i] = sum_q[i] + SUM_W'($signed(raw_c[i]));
        end
    end

    // Block averaging. The arithmetic shift rounds toward -inf.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q      <= '0;
            tilt_valid <= 1'b0;
            for (int i = 0; i < 3; i++) begin
                sum_q[i] <= '0;
                avg_q[i] <= '0;
            end
        end else begin
            tilt_valid <= 1'b0;
            if (sample_valid) begin
                if (last_c) begin
                    cnt_q      <= '0;
                    tilt_valid <= 1'b1;
                    for (int i = 0; i < 3; i++) begin
                        sum_q[i] <= '0;
                        avg_q[i] <= 10'(sum_next_c[i] >>> AVG_LOG2);
                    end
                end else begin
                    cnt_q <= cnt_q + CNT_W'(1);
                    for (int i = 0; i < 3; i++) begin
                        sum_q[i] <= sum_next_c[i];
                    end
                end
            end
        end
    end

    // Magnitude beyond the deadzone, and the phase sum for the next tick.
    // -512 has no positive 10-bit twin, so it saturates to 511.
    always_comb begin
        for (int i = 0; i < 2; i++) begin
            if (avg_q[i] == 10'h200) begin
                mag_c[i] = 9'd511;
            end else if (avg_q[i][9]) begin
                mag_c[i] = 9'(-avg_q[i]);
            end else begin
                mag_c[i] = avg_q[i][8:0];
            end
            rate_c[i]      = (mag_c[i] > DZ) ? (mag_c[i] - DZ) : 9'd0;
            phase_sum_c[i] = {1'b0, phase_q[i]} + {1'b0, rate_q[i]};
            step_c[i]      = tick_c && phase_sum_c[i][9];
        end
    end

    // Rate tick divider.
    always_ff @(posedge clk) begin
        if (rst) begin
            tick_cnt_q <= '0;
        end else if (tick_c) begin
            tick_cnt_q <= '0;
        end else begin
            tick_cnt_q <= tick_cnt_q + TICK_W'(1);
        end
    end

    // Rate/sign pipeline, phase accumulators and step outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            xAxis <= '0;
            yAxis <= '0;
            for (int i = 0; i < 2; i++) begin
                rate_q[i]  <= '0;
                sign_q[i]  <= 1'b0;
                phase_q[i] <= '0;
            end
        end else begin
            for (int i = 0; i < 2; i++) begin
                rate_q[i] <= rate_c[i];
                sign_q[i] <= avg_q[i][9];
                // An idle axis restarts from zero phase when motion resumes.
                if (rate_q[i] == 9'd0) begin
                    phase_q[i] <= '0;
                end else if (tick_c) begin
                    phase_q[i] <= phase_sum_c[i][8:0];
                end
            end
            xAxis <= {sign_q[0], step_c[0] ? 9'd1 : 9'd0};
            yAxis <= {sign_q[1], step_c[1] ? 9'd1 : 9'd0};
        end
    end

endmodule

// File: tb/tb_tilt_stepper.sv
module tb_tilt_stepper;

    localparam int unsigned AVG_LOG2 = 2;
    localparam int unsigned DEADZONE = 8;
    localparam int unsigned TICK_DIV = 4;

    logic       clk = 1'b0;
    logic       rst;
    logic       sample_valid;
    logic [9:0] x_raw, y_raw, z_raw;
    logic [9:0] xAxis, yAxis, zAxis;
    logic       tilt_valid;

    tilt_stepper #(
        .AVG_LOG2(AVG_LOG2),
        .DEADZONE(DEADZONE),
        .TICK_DIV(TICK_DIV)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .sample_valid(sample_valid),
        .x_raw       (x_raw),
        .y_raw       (y_raw),
        .z_raw       (z_raw),
        .xAxis       (xAxis),
        .yAxis       (yAxis),
        .zAxis       (zAxis),
        .tilt_valid  (tilt_valid)
    );

    always #5 clk = ~clk;

    // Cycle index; stable at the negedge where inputs are driven and outputs sampled.
    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_cmp = 0;
    int n_bad = 0;

    typedef struct packed {int cyc; logic [9:0] z; logic [9:0] xa; logic [9:0] ya;} tv_exp_t;
    typedef struct packed {int cyc; logic [9:0] xa; logic [9:0] ya;} dir_exp_t;
    typedef struct packed {int cyc; logic [9:0] v;} pulse_t;
    typedef int quad_t [4];

    tv_exp_t  tv_q[$];
    dir_exp_t dir_q[$];
    pulse_t   px_q[$];

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
        n_cmp++;
        if (got !== want) begin
            n_bad++;
            $display("FAIL %s at cycle %0d: got %0h, expected %0h", name, cyc, got, want);
        end
    endtask

    task automatic flag_fail(input string name, input logic [31:0] got);
        n_cmp++;
        n_bad++;
        $display("FAIL %s at cycle %0d: got %0h, expected none", name, cyc, got);
    endtask

    task automatic wait_cyc(input int c);
        while (cyc < c) @(negedge clk);
    endtask

    task automatic check_idle(input string name);
        check({name, " xAxis"}, 32'(xAxis), 32'h0);
        check({name, " yAxis"}, 32'(yAxis), 32'h0);
        check({name, " zAxis"}, 32'(zAxis), 32'h0);
        check({name, " tilt_valid"}, 32'(tilt_valid), 32'h0);
    endtask

    // Four back-to-back samples starting at cycle s, plus the expected results.
    task automatic batch(input int s, input quad_t qx, input quad_t qy, input quad_t qz,
                         input logic [9:0] z_exp, input logic [9:0] xa_exp, input logic [9:0] ya_exp);
        tv_q.push_back('{s + 4, z_exp, xa_exp, ya_exp});
        for (int i = 0; i < 4; i++) begin
            wait_cyc(s + i);
            sample_valid = 1'b1;
            x_raw = 10'(qx[i]);
            y_raw = 10'(qy[i]);
            z_raw = 10'(qz[i]);
        end
        wait_cyc(s + 4);
        sample_valid = 1'b0;
    endtask

    // Monitor: pops expectations whenever the DUT presents an average or a step.
    always @(negedge clk) begin
        if (tilt_valid === 1'b1) begin
            if (tv_q.size() == 0) begin
                flag_fail("tilt_valid unexpected", 32'(zAxis));
            end else begin
                check("tilt_valid cycle", 32'(cyc), 32'(tv_q[0].cyc));
                check("zAxis avg", 32'(zAxis), 32'(tv_q[0].z));
                dir_q.push_back('{cyc + 2, tv_q[0].xa, tv_q[0].ya});
                tv_q.delete(0);
            end
        end
        if (tv_q.size() > 0 && tv_q[0].cyc < cyc) begin
            flag_fail("tilt_valid missing", 32'(tv_q[0].cyc));
            tv_q.delete(0);
        end
        if (dir_q.size() > 0 && dir_q[0].cyc == cyc) begin
            check("xAxis direction", 32'(xAxis), 32'(dir_q[0].xa));
            check("yAxis direction", 32'(yAxis), 32'(dir_q[0].ya));
            dir_q.delete(0);
        end
        while (px_q.size() > 0 && px_q[0].cyc < cyc) begin
            flag_fail("x step missing", 32'(px_q[0].cyc));
            px_q.delete(0);
        end
        if (xAxis[8:0] != 9'd0) begin
            if (px_q.size() > 0 && px_q[0].cyc == cyc) begin
                check("x step", 32'(xAxis), 32'(px_q[0].v));
                px_q.delete(0);
            end else begin
                flag_fail("x step unexpected", 32'(xAxis));
            end
        end
        if (yAxis[8:0] != 9'd0) begin
            flag_fail("y step unexpected", 32'(yAxis));
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog at cycle %0d: got timeout, expected completion", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        quad_t qx, qy, qz;
        // Ticks fall on cycles 2 mod 4, so steps appear on cycles 3 mod 4.
        px_q.push_back('{43, 10'h001});
        px_q.push_back('{51, 10'h001});
        px_q.push_back('{59, 10'h001});
        px_q.push_back('{67, 10'h001});
        px_q.push_back('{75, 10'h201});
        px_q.push_back('{79, 10'h201});
        px_q.push_back('{83, 10'h201});
        px_q.push_back('{87, 10'h201});
        px_q.push_back('{91, 10'h201});
        px_q.push_back('{115, 10'h001});
        px_q.push_back('{123, 10'h001});
        px_q.push_back('{131, 10'h001});
        px_q.push_back('{139, 10'h201});
        px_q.push_back('{143, 10'h201});
        px_q.push_back('{147, 10'h201});
        px_q.push_back('{151, 10'h201});

        rst = 1'b1;
        sample_valid = 1'b1;
        x_raw = 10'd77;
        y_raw = 10'd77;
        z_raw = 10'd77;
        for (int c = 1; c <= 3; c++) begin
            wait_cyc(c);
            check_idle("reset");
            sample_valid = (c == 2);
            rst = (c != 3);
        end

        // Rounding toward -inf: x 7/4 -> 1, y -5/4 -> -2, z 406/4 -> 101.
        qx = '{3, 3, 3, -2}; qy = '{-1, -1, -1, -2}; qz = '{100, 101, 102, 103};
        batch(8, qx, qy, qz, 10'd101, 10'h000, 10'h200);
        // x -5/4 -> -2, y +1, z -15/4 -> -4.
        qx = '{-1, -1, -1, -2}; qy = '{3, 3, 3, -2}; qz = '{-3, -4, -4, -4};
        batch(20, qx, qy, qz, 10'h3FC, 10'h200, 10'h000);
        // x 264 -> rate 256: a step every 2 ticks.
        qx = '{264, 264, 264, 264}; qy = '{0, 0, 0, 0}; qz = '{10, -10, 20, -20};
        batch(32, qx, qy, qz, 10'h000, 10'h000, 10'h000);
        // x -512 saturates -> rate 503; y -5 stays idle but shows direction.
        qx = '{-512, -512, -512, -512}; qy = '{-5, -5, -5, -5}; qz = '{-512, -512, -512, -512};
        batch(64, qx, qy, qz, 10'h200, 10'h200, 10'h200);
        // x +8 is inside the deadzone: steps stop, phase clears.
        qx = '{8, 8, 8, 8}; qy = '{0, 0, 0, 0}; qz = '{1, 2, 3, 4};
        batch(88, qx, qy, qz, 10'd2, 10'h000, 10'h000);
        // Resume at rate 256: first step two ticks later.
        qx = '{264, 264, 264, 264}; qy = '{0, 0, 0, 0}; qz = '{-1, 0, 0, 0};
        batch(104, qx, qy, qz, 10'h3FF, 10'h000, 10'h000);
        // Last sample lands on tick cycle 130, and that tick still uses rate 256.
        qx = '{-512, -512, -512, -512}; qy = '{0, 0, 0, 0}; qz = '{511, 511, 511, 511};
        batch(127, qx, qy, qz, 10'h1FF, 10'h200, 10'h000);

        // Partial average interrupted by reset.
        wait_cyc(150);
        sample_valid = 1'b1;
        x_raw = 10'd0;
        y_raw = 10'd0;
        z_raw = 10'd400;
        wait_cyc(151);
        wait_cyc(152);
        sample_valid = 1'b0;
        rst = 1'b1;
        wait_cyc(153);
        check_idle("mid reset");
        wait_cyc(154);
        check_idle("mid reset");
        rst = 1'b0;

        qx = '{0, 0, 0, 0}; qy = '{0, 0, 0, 0}; qz = '{4, 4, 4, 4};
        batch(156, qx, qy, qz, 10'd4, 10'h000, 10'h000);

        wait_cyc(170);
        check("pending averages", 32'(tv_q.size()), 32'h0);
        check("pending directions", 32'(dir_q.size()), 32'h0);
        check("pending x steps", 32'(px_q.size()), 32'h0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
